// File: rtl/noteplayer_pkg.sv
// noteplayer_pkg: shared waveform/state enums, rest note and phase-increment table function
package noteplayer_pkg;
  typedef enum logic [1:0] {WAVE_SAW, WAVE_SQUARE, WAVE_TRI, WAVE_SILENT} wave_t;
  typedef enum logic {ST_IDLE, ST_PLAY} state_t;
  localparam int REST_NOTE = 0;
  // Only ever called with constant arguments, so the real maths folds away at elaboration.
  function automatic longint note_inc(int note, int phase_w, int fs);
    real f;
    f = 440.0 * 2.0 ** ((note - 49) / 12.0);
    return (note == REST_NOTE) ? 64'sd0 : longint'(f * 2.0 ** phase_w / fs);
  endfunction
endpackage

// File: rtl/np_voice.sv
// np_voice: one phase accumulator plus waveform generator; value is registered, 0 when not advancing
module np_voice
  import noteplayer_pkg::*;
#(
  parameter int PHASE_W  = 20,
  parameter int SAMPLE_W = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       advance,
  input  logic                       clear,
  input  logic [PHASE_W-1:0]         inc,
  input  wave_t                      waveform,
  output logic signed [SAMPLE_W-1:0] value
);
  localparam logic [SAMPLE_W-1:0] H = {1'b1, {(SAMPLE_W-1){1'b0}}};
  logic [PHASE_W-1:0] phase, nxt;
  logic [SAMPLE_W-1:0] p, t, w;
  always_comb begin
    nxt = phase + inc;
    p = nxt[PHASE_W-1 -: SAMPLE_W];
    t = p[SAMPLE_W-1] ? ~(p << 1) : (p << 1);
    w = waveform == WAVE_SAW    ? p - H :
        waveform == WAVE_SQUARE ? (p[SAMPLE_W-1] ? H + SAMPLE_W'(1) : H - SAMPLE_W'(1)) :
        waveform == WAVE_TRI    ? t - H : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      phase <= '0;
      value <= '0;
    end else begin
      phase <= clear ? '0 : advance ? nxt : phase;
      value <= advance ? $signed(w) : '0;
    end
endmodule

// File: rtl/poly_noteplayer.sv
// poly_noteplayer: polyphonic beat-timed note player, VOICES voices mixed to one signed sample, 2-cycle sample latency
module poly_noteplayer
  import noteplayer_pkg::*;
#(
  parameter int VOICES   = 4,
  parameter int NOTE_W   = 6,
  parameter int DUR_W    = 6,
  parameter int SAMPLE_W = 16,
  parameter int PHASE_W  = 20,
  parameter int FS       = 48000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         play_enable,
  input  logic                         load_new_note,
  input  logic [VOICES*NOTE_W-1:0]     notes,
  input  logic [$clog2(VOICES)-1:0]    num_notes,
  input  logic [1:0]                   waveform,
  input  logic [DUR_W-1:0]             duration,
  input  logic                         beat,
  input  logic                         generate_next_sample,
  output logic                         load_ready,
  output logic                         playing,
  output logic                         note_done,
  output logic signed [SAMPLE_W-1:0]   sample_out,
  output logic                         new_sample_ready
);
  localparam int LV = $clog2(VOICES);
  localparam int MW = SAMPLE_W + LV;
  state_t state, next_state;
  logic [VOICES*NOTE_W-1:0] notes_q;
  logic [LV-1:0] nn_q;
  wave_t wave_q;
  logic [DUR_W-1:0] dur_q, cnt;
  logic req_q, load_ok, last, run;
  logic [PHASE_W-1:0] inc_tab [1<<NOTE_W];
  logic signed [SAMPLE_W-1:0] vals [VOICES];
  logic signed [MW-1:0] sum;
  for (genvar n = 0; n < (1 << NOTE_W); n++) begin : g_inc
    localparam longint IV = note_inc(n, PHASE_W, FS);
    assign inc_tab[n] = PHASE_W'(IV);
  end
  for (genvar i = 0; i < VOICES; i++) begin : g_v
    logic [NOTE_W-1:0] nt;
    assign nt = notes_q[i*NOTE_W +: NOTE_W];
    np_voice #(.PHASE_W(PHASE_W), .SAMPLE_W(SAMPLE_W)) u_voice (
      .clk      (clk),
      .reset    (reset),
      .advance  (run && generate_next_sample && nt != NOTE_W'(REST_NOTE) && LV'(i) <= nn_q),
      .clear    (load_ok),
      .inc      (inc_tab[nt]),
      .waveform (wave_q),
      .value    (vals[i])
    );
  end
  assign load_ready = state == ST_IDLE;
  assign playing = state == ST_PLAY;
  always_comb begin
    run = state == ST_PLAY && play_enable;
    load_ok = state == ST_IDLE && load_new_note && duration != '0;
    last = run && beat && cnt == dur_q - DUR_W'(1);
    next_state = load_ok ? ST_PLAY : last ? ST_IDLE : state;
    sum = '0;
    for (int k = 0; k < VOICES; k++) sum = sum + MW'(vals[k]);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= ST_IDLE;
      notes_q <= '0;
      nn_q <= '0;
      wave_q <= WAVE_SAW;
      dur_q <= '0;
      cnt <= '0;
      req_q <= 1'b0;
      note_done <= 1'b0;
      new_sample_ready <= 1'b0;
      sample_out <= '0;
    end else begin
      state <= next_state;
      if (load_ok) begin
        notes_q <= notes;
        nn_q <= num_notes;
        wave_q <= wave_t'(waveform);
        dur_q <= duration;
        cnt <= '0;
      end else if (run && beat) cnt <= cnt + DUR_W'(1);
      note_done <= last;
      req_q <= generate_next_sample;
      new_sample_ready <= req_q;
      sample_out <= SAMPLE_W'(sum >>> LV);
    end
endmodule

// File: tb/tb_poly_noteplayer.sv
// tb_poly_noteplayer: directed plus random stimulus against a behavioural note-player model
module tb_poly_noteplayer;
  logic clk = 0;
  logic reset, play_enable, load_new_note, beat, gen;
  logic [23:0] notes;
  logic [1:0] num_notes, waveform;
  logic [5:0] duration;
  logic load_ready, playing, note_done, new_sample_ready;
  logic signed [15:0] sample_out;
  int checks = 0, errors = 0, done_cnt = 0;
  bit m_play, p1_v, o_v, o_done;
  int m_note [4];
  int m_ph [4];
  int m_nn, m_wave, m_dur, m_beats, p1_s, o_s;
  int inc_t [64];

  poly_noteplayer dut (
    .clk(clk), .reset(reset), .play_enable(play_enable), .load_new_note(load_new_note),
    .notes(notes), .num_notes(num_notes), .waveform(waveform), .duration(duration),
    .beat(beat), .generate_next_sample(gen), .load_ready(load_ready), .playing(playing),
    .note_done(note_done), .sample_out(sample_out), .new_sample_ready(new_sample_ready)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int wave_val(int w, int ph);
    int p, t;
    p = ph >> 4;
    t = (p >= 32768) ? (~(p << 1)) & 65535 : (p << 1) & 65535;
    case (w)
      0: return p - 32768;
      1: return (p < 32768) ? 32767 : -32767;
      2: return t - 32768;
      default: return 0;
    endcase
  endfunction

  task automatic mreset();
    m_play = 0; p1_v = 0; o_v = 0; o_done = 0; p1_s = 0; o_s = 0; m_beats = 0;
    for (int v = 0; v < 4; v++) m_ph[v] = 0;
  endtask

  task automatic model_step();
    bit was, run;
    int sum;
    was = m_play;
    run = m_play && play_enable;
    sum = 0;
    o_v = p1_v;
    o_s = p1_s;
    if (gen && run)
      for (int v = 0; v < 4; v++)
        if (v <= m_nn && m_note[v] != 0) begin
          m_ph[v] = (m_ph[v] + inc_t[m_note[v]]) % (1 << 20);
          sum += wave_val(m_wave, m_ph[v]);
        end
    p1_v = gen;
    p1_s = sum >>> 2;
    o_done = 0;
    if (run && beat) begin
      m_beats++;
      if (m_beats == m_dur) begin
        m_play = 0;
        o_done = 1;
      end
    end
    if (!was && load_new_note && duration != 0) begin
      for (int v = 0; v < 4; v++) begin
        m_note[v] = notes[v*6 +: 6];
        m_ph[v] = 0;
      end
      m_nn = num_notes;
      m_wave = waveform;
      m_dur = duration;
      m_beats = 0;
      m_play = 1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset) mreset(); else model_step();
    #1;
    check("playing", playing, m_play);
    check("load_ready", load_ready, !m_play);
    check("note_done", note_done, o_done);
    check("new_sample_ready", new_sample_ready, o_v);
    if (o_v) check("sample_out", sample_out, o_s);
    if (note_done) done_cnt++;
    load_new_note = 0;
    beat = 0;
    gen = 0;
  endtask

  task automatic load(input logic [23:0] n, input int nn, input int w, input int d);
    notes = n; num_notes = 2'(nn); waveform = 2'(w); duration = 6'(d);
    load_new_note = 1;
    tick();
  endtask

  initial begin
    for (int n = 0; n < 64; n++)
      inc_t[n] = (n == 0) ? 0 : int'(440.0 * 2.0 ** ((n - 49) / 12.0) * 1048576.0 / 48000.0);
    reset = 1; play_enable = 1; load_new_note = 0; beat = 0; gen = 1;
    notes = 0; num_notes = 0; waveform = 0; duration = 0;
    mreset();
    #1;
    check("rst_playing", playing, 0);
    check("rst_load_ready", load_ready, 1);
    check("rst_sample", sample_out, 0);
    check("rst_nsr", new_sample_ready, 0);
    gen = 1; tick();
    gen = 1; tick();
    @(negedge clk) reset = 0;
    tick();
    check("rst_req_dropped", new_sample_ready, 0);
    // single saw voice, A4
    load({18'd0, 6'd49}, 0, 0, 4);
    gen = 1; tick();
    tick();
    check("t2_nsr", new_sample_ready, 1);
    check("t2_sample", sample_out, -8042);
    for (int i = 0; i < 6; i++) begin gen = 1; tick(); end
    check("t2_b2b_nsr", new_sample_ready, 1);
    for (int i = 0; i < 20 && m_play; i++) begin beat = 1; tick(); end
    // three-voice square chord
    load({6'd0, 6'd47, 6'd44, 6'd40}, 2, 1, 3);
    gen = 1; tick();
    tick();
    check("t3_sample", sample_out, 24575);
    // duration expiry with a load on the final beat
    done_cnt = 0;
    for (int b = 0; b < 3; b++) begin
      repeat (99) tick();
      beat = 1;
      if (b == 2) begin load_new_note = 1; duration = 5; end
      tick();
    end
    check("t4_done", note_done, 1);
    check("t4_playing", playing, 0);
    tick();
    check("t4_done_once", done_cnt, 1);
    check("t4_ready", load_ready, 1);
    load({18'd0, 6'd49}, 0, 0, 0);
    check("t4_zero_dur", playing, 0);
    // pause freezes beats and phase
    load({18'd0, 6'd49}, 0, 0, 3);
    beat = 1; tick();
    for (int i = 0; i < 3; i++) begin gen = 1; tick(); end
    play_enable = 0;
    for (int i = 0; i < 5; i++) begin beat = 1; tick(); gen = 1; tick(); end
    tick();
    check("t5_pause_sample", sample_out, 0);
    check("t5_pause_playing", playing, 1);
    play_enable = 1;
    gen = 1; tick();
    tick();
    check("t5_resume", sample_out, -7592);
    beat = 1; tick();
    check("t5_still_playing", playing, 1);
    beat = 1; tick();
    check("t5_done", note_done, 1);
    // async reset mid-note with requests in flight
    load({18'd0, 6'd49}, 0, 0, 10);
    gen = 1; tick();
    gen = 1; tick();
    gen = 1;
    reset = 1;
    #1;
    mreset();
    check("t6_playing", playing, 0);
    check("t6_nsr", new_sample_ready, 0);
    check("t6_sample", sample_out, 0);
    tick();
    @(negedge clk) reset = 0;
    tick();
    tick();
    load({18'd0, 6'd49}, 0, 0, 4);
    gen = 1; tick();
    tick();
    check("t6_restart", sample_out, -8042);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      play_enable = ($urandom_range(9) != 0);
      gen = 1'($urandom_range(1));
      beat = ($urandom_range(7) == 0);
      if ($urandom_range(9) == 0) begin
        load_new_note = 1;
        notes = 24'($urandom);
        num_notes = 2'($urandom);
        waveform = 2'($urandom);
        duration = 6'($urandom_range(5));
      end
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
